// File: rtl/platform_manager.sv
// Platform manager: holds NUM_BLOCKS platforms, scans them for a doodle
// landing on one, and scrolls the world down when the doodle climbs above
// SCROLL_LINE. Platforms that fall off the bottom respawn at the top.
//
// Handshake: physicsUpdate is a request that is accepted only in a cycle
// where busy==0; a request seen while busy==1 is dropped, not queued.
// scanDone marks the single cycle in which a new result is published.
// There is no back-pressure on the result side.
module platform_manager #(
  parameter int SCREEN_WIDTH  = 400,
  parameter int SCREEN_HEIGHT = 700,
  parameter int BLOCK_WIDTH   = 40,
  parameter int BLOCK_HEIGHT  = 5,
  parameter int NUM_BLOCKS    = 8,
  parameter int SCROLL_LINE   = 350
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        physicsUpdate,
  input  logic [31:0] doodleX,
  input  logic [31:0] doodleY,
  input  logic        falling,
  input  logic [2:0]  blockSel,
  output logic        hasCollide,
  output logic [2:0]  hitIndex,
  output logic        scanDone,
  output logic        scrollValid,
  output logic [31:0] scrollDelta,
  output logic [31:0] blockX,
  output logic [31:0] blockY,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SCROLL = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0] X_MAX    = 32'(SCREEN_WIDTH - BLOCK_WIDTH);
  localparam logic [31:0] Y_TOP    = 32'(SCREEN_HEIGHT - BLOCK_HEIGHT);
  localparam logic [31:0] BW       = 32'(BLOCK_WIDTH);
  localparam logic [31:0] BH       = 32'(BLOCK_HEIGHT);
  localparam logic [31:0] SCROLL_L = 32'(SCROLL_LINE);
  localparam logic [31:0] X_CENTER = 32'(SCREEN_WIDTH / 2 - BLOCK_WIDTH / 2);
  localparam int          ROW      = SCREEN_HEIGHT / NUM_BLOCKS;
  localparam logic [2:0]  LAST     = 3'(NUM_BLOCKS - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] snap_x;
  logic [31:0] snap_y;
  logic        snap_falling;
  logic        hit_found;
  logic [2:0]  hit_idx;
  logic        scrolled;
  logic [15:0] lfsr;
  logic [31:0] blk_x [NUM_BLOCKS];
  logic [31:0] blk_y [NUM_BLOCKS];

  logic        cur_hit;
  logic [31:0] delta;
  logic [31:0] lfsr_lo;
  logic [31:0] spawn_x;

  // Landing test against the platform selected by the scan index, plus the
  // scroll amount and the wrapped respawn X shared by every respawn this cycle.
  always_comb begin
    cur_hit = snap_falling
           && (blk_x[idx] <= snap_x) && (snap_x <= blk_x[idx] + BW - 32'd1)
           && (blk_y[idx] <= snap_y) && (snap_y <= blk_y[idx] + BH);
    delta   = snap_y - SCROLL_L;
    lfsr_lo = 32'(lfsr[8:0]);
    spawn_x = (lfsr_lo >= X_MAX) ? (lfsr_lo - X_MAX) : lfsr_lo;
  end

  assign blockX    = blk_x[blockSel];
  assign blockY    = blk_y[blockSel];
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) for respawn positions.
  always_ff @(posedge clk) begin
    if (!reset) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Scan/scroll FSM with registered results and the platform store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= 3'd0;
      snap_x       <= 32'd0;
      snap_y       <= 32'd0;
      snap_falling <= 1'b0;
      hit_found    <= 1'b0;
      hit_idx      <= 3'd0;
      scrolled     <= 1'b0;
      hasCollide   <= 1'b0;
      hitIndex     <= 3'd0;
      scanDone     <= 1'b0;
      scrollValid  <= 1'b0;
      scrollDelta  <= 32'd0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (i == 0) begin
          blk_x[i] <= X_CENTER;
          blk_y[i] <= 32'd0;
        end else begin
          blk_x[i] <= 32'(i * 45);
          blk_y[i] <= 32'(i * ROW);
        end
      end
    end else begin
      scanDone    <= 1'b0;
      scrollValid <= 1'b0;
      case (state)
        IDLE: begin
          if (physicsUpdate) begin
            snap_x       <= doodleX;
            snap_y       <= doodleY;
            snap_falling <= falling;
            hit_found    <= 1'b0;
            hit_idx      <= 3'd0;
            scrolled     <= 1'b0;
            idx          <= 3'd0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          // First hit wins; later hits never overwrite the latch.
          if (cur_hit && !hit_found) begin
            hit_found <= 1'b1;
            hit_idx   <= idx;
          end
          if (idx == LAST) state <= (snap_y > SCROLL_L) ? SCROLL : DONE;
          else             idx   <= idx + 3'd1;
        end
        SCROLL: begin
          for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (blk_y[i] >= delta) begin
              blk_y[i] <= blk_y[i] - delta;
            end else begin
              blk_y[i] <= Y_TOP;
              blk_x[i] <= spawn_x;
            end
          end
          scrollDelta <= delta;
          scrolled    <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          hasCollide  <= hit_found;
          hitIndex    <= hit_idx;
          scanDone    <= 1'b1;
          scrollValid <= scrolled;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_manager.sv
// Bench for platform_manager: directed vector table, hand-written corner
// sequences (scroll, dropped strobe, reset mid-operation) and random scans
// checked against a reference model of the platform world.
module tb_platform_manager;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        physicsUpdate = 1'b0;
  logic [31:0] doodleX = 32'd0;
  logic [31:0] doodleY = 32'd0;
  logic        falling = 1'b0;
  logic [2:0]  blockSel = 3'd0;
  logic        hasCollide;
  logic [2:0]  hitIndex;
  logic        scanDone;
  logic        scrollValid;
  logic [31:0] scrollDelta;
  logic [31:0] blockX;
  logic [31:0] blockY;
  logic        busy;
  logic [1:0]  fsm_state;

  always #10 clk = ~clk;

  platform_manager dut (
    .clk(clk), .reset(reset), .physicsUpdate(physicsUpdate),
    .doodleX(doodleX), .doodleY(doodleY), .falling(falling),
    .blockSel(blockSel), .hasCollide(hasCollide), .hitIndex(hitIndex),
    .scanDone(scanDone), .scrollValid(scrollValid), .scrollDelta(scrollDelta),
    .blockX(blockX), .blockY(blockY), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- reference model ----------------
  int unsigned m_x [8];
  int unsigned m_y [8];
  int unsigned m_delta;
  logic [15:0] lfsr_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk) lfsr_m <= reset ? lfsr_step(lfsr_m) : 16'hACE1;

  task automatic model_reset();
    m_x[0] = 180; m_y[0] = 0;
    for (int i = 1; i < 8; i++) begin
      m_x[i] = i * 45;
      m_y[i] = i * 87;
    end
    m_delta = 0;
  endtask

  // Predicts one scan from the landing and scrolling rules and updates the world.
  task automatic model_scan(input int unsigned x, input int unsigned y, input bit f,
                            input logic [15:0] lv, output bit e_hit, output int e_idx,
                            output bit e_sv, output int e_lat);
    int unsigned d, l9;
    e_hit = 0; e_idx = 0;
    for (int i = 0; i < 8; i++)
      if (!e_hit && f && x >= m_x[i] && x <= m_x[i] + 39 && y >= m_y[i] && y <= m_y[i] + 5) begin
        e_hit = 1; e_idx = i;
      end
    e_sv  = (y > 350);
    e_lat = e_sv ? 10 : 9;
    if (e_sv) begin
      d  = y - 350;
      l9 = lv % 512;
      m_delta = d;
      for (int i = 0; i < 8; i++)
        if (m_y[i] >= d) m_y[i] = m_y[i] - d;
        else begin
          m_y[i] = 695;
          m_x[i] = (l9 >= 360) ? l9 - 360 : l9;
        end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; physicsUpdate = 1'b0;
    tick(); tick();
    reset = 1'b1;
    model_reset();
  endtask

  // One strobe, then wait (bounded) for scanDone and capture the result.
  task automatic run_scan(input logic [31:0] x, input logic [31:0] y, input bit f,
                          input bit scramble, output int lat, output bit r_hit,
                          output int r_idx, output bit r_sv, output logic [15:0] lrec);
    doodleX = x; doodleY = y; falling = f;
    physicsUpdate = 1'b1;
    tick();
    physicsUpdate = 1'b0;
    if (scramble) begin
      doodleX = $urandom; doodleY = $urandom; falling = ~f;
    end
    lat = -1; r_hit = 0; r_idx = 0; r_sv = 0; lrec = 16'h0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) chk("busy_mid_scan", busy, 1);
      if (k == 8) lrec = lfsr_m;
      if (scanDone) begin
        lat = k; r_hit = hasCollide; r_idx = hitIndex; r_sv = scrollValid;
        break;
      end
    end
    if (lat < 0) chk("scan_timeout", 0, 1);
  endtask

  task automatic check_platforms(input string tag);
    for (int i = 0; i < 8; i++) begin
      blockSel = 3'(i);
      #1;
      chk({tag, "_x"}, blockX, m_x[i]);
      chk({tag, "_y"}, blockY, m_y[i]);
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (scanDone) n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        f;
    logic        exp_hit;
    logic [2:0]  exp_idx;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int lat, r_idx, e_idx, e_lat, n;
    bit r_hit, r_sv, e_hit, e_sv;
    logic [15:0] lrec;
    logic [31:0] l9, xr, yr;

    vecs[0] = '{32'd200, 32'd3,   1'b1, 1'b1, 3'd0};
    vecs[1] = '{32'd200, 32'd3,   1'b0, 1'b0, 3'd0};
    vecs[2] = '{32'd219, 32'd5,   1'b1, 1'b1, 3'd0};
    vecs[3] = '{32'd220, 32'd5,   1'b1, 1'b0, 3'd0};
    vecs[4] = '{32'd180, 32'd6,   1'b1, 1'b0, 3'd0};
    vecs[5] = '{32'd60,  32'd92,  1'b1, 1'b1, 3'd1};
    vecs[6] = '{32'd174, 32'd266, 1'b1, 1'b1, 3'd3};
    vecs[7] = '{32'd175, 32'd261, 1'b1, 1'b0, 3'd0};

    do_reset();
    chk("rst_hasCollide", hasCollide, 0);
    chk("rst_hitIndex", hitIndex, 0);
    chk("rst_scanDone", scanDone, 0);
    chk("rst_scrollValid", scrollValid, 0);
    chk("rst_scrollDelta", scrollDelta, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", fsm_state, 0);
    check_platforms("rst_plat");

    // Directed table against the reset world (no scroll).
    for (int v = 0; v < 8; v++) begin
      run_scan(vecs[v].x, vecs[v].y, vecs[v].f, 0, lat, r_hit, r_idx, r_sv, lrec);
      chk($sformatf("vec%0d_latency", v), lat, 9);
      chk($sformatf("vec%0d_hit", v), r_hit, vecs[v].exp_hit);
      chk($sformatf("vec%0d_idx", v), r_idx, vecs[v].exp_idx);
      chk($sformatf("vec%0d_scroll", v), r_sv, 0);
    end
    blockSel = 3'd3; #1;
    chk("sel3_x", blockX, 135);
    chk("sel3_y", blockY, 261);

    // Outputs hold across idle cycles.
    tick(); tick(); tick();
    chk("hold_hasCollide", hasCollide, 0);
    chk("hold_scanDone", scanDone, 0);

    // Scroll from the reset world.
    run_scan(200, 400, 0, 0, lat, r_hit, r_idx, r_sv, lrec);
    chk("scroll_latency", lat, 10);
    chk("scroll_valid", r_sv, 1);
    chk("scroll_delta", scrollDelta, 50);
    chk("scroll_hit", r_hit, 0);
    blockSel = 3'd1; #1;
    chk("scroll_p1_y", blockY, 37);
    blockSel = 3'd0; #1;
    chk("scroll_p0_y", blockY, 695);
    chk("scroll_p0_x_range", blockX < 360, 1);
    l9 = {23'd0, lrec[8:0]};
    chk("scroll_p0_x", blockX, (l9 >= 360) ? l9 - 360 : l9);
    model_scan(200, 400, 0, lrec, e_hit, e_idx, e_sv, e_lat);
    check_platforms("scroll_plat");
    tick();
    chk("scroll_valid_pulse", scrollValid, 0);

    // Non-scrolling scan keeps the previous scrollDelta.
    run_scan(0, 10, 0, 0, lat, r_hit, r_idx, r_sv, lrec);
    chk("noscroll_valid", r_sv, 0);
    chk("delta_hold", scrollDelta, 50);

    // Strobe while busy is dropped.
    do_reset();
    doodleX = 200; doodleY = 3; falling = 1;
    physicsUpdate = 1'b1; tick(); physicsUpdate = 1'b0;
    tick(); tick();
    physicsUpdate = 1'b1; tick(); physicsUpdate = 1'b0;
    n = 0; lat = -1;
    for (int k = 4; k < 30; k++) begin
      tick();
      if (scanDone) begin n++; if (lat < 0) lat = k; end
    end
    chk("drop_done_count", n, 1);
    chk("drop_latency", lat, 9);
    chk("drop_hit", hasCollide, 1);

    // Reset during SCAN abandons the scan.
    run_scan(60, 90, 1, 0, lat, r_hit, r_idx, r_sv, lrec);
    chk("pre_rst_idx", r_idx, 1);
    doodleX = 200; doodleY = 3; falling = 1;
    physicsUpdate = 1'b1; tick(); physicsUpdate = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1;
    model_reset();
    chk("midscan_busy", busy, 0);
    chk("midscan_hasCollide", hasCollide, 0);
    chk("midscan_hitIndex", hitIndex, 0);
    chk("midscan_scanDone", scanDone, 0);
    count_done(15, n);
    chk("midscan_no_done", n, 0);

    // Reset during SCROLL abandons the scroll.
    doodleX = 0; doodleY = 400; falling = 0;
    physicsUpdate = 1'b1; tick(); physicsUpdate = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    chk("midscroll_state", fsm_state, 2);
    reset = 1'b0; tick(); reset = 1'b1;
    model_reset();
    chk("midscroll_busy", busy, 0);
    count_done(15, n);
    chk("midscroll_no_done", n, 0);
    chk("midscroll_delta", scrollDelta, 0);
    check_platforms("midscroll_plat");

    // Random scans against the reference model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int mode, p;
      bit f;
      mode = $urandom_range(0, 9);
      p = $urandom_range(0, 7);
      f = ($urandom_range(0, 3) != 0);
      if (mode <= 5) begin
        xr = m_x[p] + $urandom_range(0, 41) - 1;
        yr = m_y[p] + $urandom_range(0, 7) - 1;
      end else if (mode <= 7) begin
        xr = $urandom_range(0, 420);
        yr = $urandom_range(0, 350);
      end else begin
        xr = $urandom_range(0, 420);
        yr = $urandom_range(351, 900);
      end
      run_scan(xr, yr, f, 1, lat, r_hit, r_idx, r_sv, lrec);
      model_scan(xr, yr, f, lrec, e_hit, e_idx, e_sv, e_lat);
      exp_q.push_back(32'(e_hit));
      exp_q.push_back(32'(e_idx));
      chk("rnd_latency", lat, e_lat);
      chk("rnd_hit", r_hit, exp_q.pop_front());
      chk("rnd_idx", r_idx, exp_q.pop_front());
      chk("rnd_scroll", r_sv, e_sv);
      chk("rnd_delta", scrollDelta, m_delta);
      if (e_sv) check_platforms("rnd_plat");
    end
    check_platforms("final_plat");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
